// File: rtl/envelope_sequencer_if.sv
// Pin bundle for envelope_sequencer: gates, config port, shared LUT port and envelope outputs.
interface envelope_sequencer_if #(
  parameter int unsigned VOICES = 4
);
  logic [VOICES-1:0]   gate;
  logic                cfg_we;
  logic [2:0]          cfg_voice;
  logic [1:0]          cfg_sel;
  logic [7:0]          cfg_data;
  logic [7:0]          lut_addr;
  logic [7:0]          lut_data;
  logic [VOICES*8-1:0] env_out;
  logic [VOICES-1:0]   env_strobe;

  modport master (
    output gate, cfg_we, cfg_voice, cfg_sel, cfg_data, lut_data,
    input  lut_addr, env_out, env_strobe
  );

  modport slave (
    input  gate, cfg_we, cfg_voice, cfg_sel, cfg_data, lut_data,
    output lut_addr, env_out, env_strobe
  );
endinterface

// File: rtl/envelope_sequencer.sv
// Time-multiplexed ADSR sequencer: VOICES voices share one exponential LUT, one voice per slot.
// Optional macro ENV_SEQ_HARD_RESTART_EN: a gate rise forces the level to 0 before the attack.
module envelope_sequencer #(
  parameter int unsigned VOICES = 4,
  parameter int unsigned ACC_W  = 12
) (
  input logic                 clk,
  input logic                 resetn,
  envelope_sequencer_if.slave bus
);
  localparam int unsigned VW = (VOICES > 1) ? $clog2(VOICES) : 1;
  localparam int unsigned SW = ACC_W + 1;

  typedef enum logic [2:0] {S_IDLE, S_ATTACK, S_DECAY, S_SUSTAIN, S_RELEASE} state_t;

  logic [VW-1:0]    slot;
  state_t           st        [VOICES];
  logic [ACC_W-1:0] acc       [VOICES];
  logic [7:0]       idx       [VOICES];
  logic [7:0]       level     [VOICES];
  logic [7:0]       rel_start [VOICES];
  logic [VOICES-1:0] gate_prev;
  logic [7:0]       atk_rate  [VOICES];
  logic [7:0]       dec_rate  [VOICES];
  logic [7:0]       sus_lvl   [VOICES];
  logic [7:0]       rel_rate  [VOICES];

  state_t           cur_st, nxt_st;
  logic [ACC_W-1:0] nxt_acc;
  logic [7:0]       cur_idx, cur_lvl, nxt_idx, nxt_lvl, nxt_rel;
  logic [7:0]       rate_c, sus_c, rel_c, dec_val_c, rel_val_c;
  logic [SW-1:0]    sum_c;
  logic             active_c, tick_c, rise_c, fall_c;
  logic [VW-1:0]    cfg_idx_c;

  assign bus.lut_addr = idx[slot];
  assign cfg_idx_c    = bus.cfg_voice[VW-1:0];

  for (genvar v = 0; v < VOICES; v++) begin : g_env
    assign bus.env_out[8*v +: 8] = level[v];
  end

  // Next state of the voice owning the current slot.
  always_comb begin
    cur_st   = st[slot];
    cur_idx  = idx[slot];
    cur_lvl  = level[slot];
    sus_c    = sus_lvl[slot];
    rel_c    = rel_start[slot];
    rise_c   = bus.gate[slot] & ~gate_prev[slot];
    fall_c   = ~bus.gate[slot] & gate_prev[slot];
    active_c = (cur_st == S_ATTACK) || (cur_st == S_DECAY) || (cur_st == S_RELEASE);
    case (cur_st)
      S_ATTACK:  rate_c = atk_rate[slot];
      S_DECAY:   rate_c = dec_rate[slot];
      S_RELEASE: rate_c = rel_rate[slot];
      default:   rate_c = 8'd0;
    endcase
    sum_c     = SW'(acc[slot]) + SW'(rate_c) + SW'(1);
    tick_c    = sum_c[ACC_W] & active_c;
    dec_val_c = sus_c + 8'((16'(8'd255 - sus_c) * 16'(bus.lut_data)) >> 8);
    rel_val_c = 8'((16'(rel_c) * 16'(bus.lut_data)) >> 8);

    nxt_st  = cur_st;
    nxt_acc = acc[slot];
    nxt_idx = cur_idx;
    nxt_lvl = cur_lvl;
    nxt_rel = rel_c;

    if (rise_c) begin
      nxt_st  = S_ATTACK;
      nxt_idx = 8'd0;
      nxt_acc = '0;
`ifdef ENV_SEQ_HARD_RESTART_EN
      nxt_lvl = 8'd0;
`endif
    end else if (fall_c && (cur_st == S_ATTACK || cur_st == S_DECAY || cur_st == S_SUSTAIN)) begin
      nxt_st  = S_RELEASE;
      nxt_rel = cur_lvl;
      nxt_idx = 8'd0;
      nxt_acc = '0;
    end else begin
      if (active_c) nxt_acc = sum_c[ACC_W-1:0];
      case (cur_st)
        S_ATTACK: if (tick_c) begin
          // Saturate so a legato start at full scale cannot wrap.
          if (cur_lvl >= 8'd254) begin
            nxt_lvl = 8'd255;
            nxt_st  = S_DECAY;
            nxt_idx = 8'd0;
          end else begin
            nxt_lvl = cur_lvl + 8'd1;
          end
        end
        S_DECAY: if (tick_c) begin
          nxt_idx = cur_idx + 8'd1;
          if (cur_idx == 8'd255) begin
            nxt_st  = S_SUSTAIN;
            nxt_lvl = sus_c;
          end else begin
            nxt_lvl = dec_val_c;
          end
        end
        S_SUSTAIN: nxt_lvl = sus_c;
        S_RELEASE: if (tick_c) begin
          nxt_idx = cur_idx + 8'd1;
          if (cur_idx == 8'd255) begin
            nxt_st  = S_IDLE;
            nxt_lvl = 8'd0;
          end else begin
            nxt_lvl = rel_val_c;
          end
        end
        default: ;
      endcase
    end
  end

  // Slot rotation, per-voice state commit and config registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      slot           <= '0;
      gate_prev      <= '0;
      bus.env_strobe <= '0;
      for (int v = 0; v < VOICES; v++) begin
        st[v]        <= S_IDLE;
        acc[v]       <= '0;
        idx[v]       <= 8'd0;
        level[v]     <= 8'd0;
        rel_start[v] <= 8'd0;
        atk_rate[v]  <= 8'd0;
        dec_rate[v]  <= 8'd0;
        sus_lvl[v]   <= 8'd0;
        rel_rate[v]  <= 8'd0;
      end
    end else begin
      slot            <= (slot == VW'(VOICES - 1)) ? '0 : slot + VW'(1);
      st[slot]        <= nxt_st;
      acc[slot]       <= nxt_acc;
      idx[slot]       <= nxt_idx;
      level[slot]     <= nxt_lvl;
      rel_start[slot] <= nxt_rel;
      gate_prev[slot] <= bus.gate[slot];
      bus.env_strobe  <= VOICES'(1) << slot;
      if (bus.cfg_we && (32'(bus.cfg_voice) < VOICES)) begin
        case (bus.cfg_sel)
          2'd0:    atk_rate[cfg_idx_c] <= bus.cfg_data;
          2'd1:    dec_rate[cfg_idx_c] <= bus.cfg_data;
          2'd2:    sus_lvl[cfg_idx_c]  <= bus.cfg_data;
          default: rel_rate[cfg_idx_c] <= bus.cfg_data;
        endcase
      end
    end
  end
endmodule
